// File: rtl/wb_queue_pkg.sv
// Shared processor types for the write-back queue.
// Register address/data widths and the queued entry layout.
package wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Bypass lookup over the stored queue entries.
// Youngest matching entry wins.
module wbq_fwd_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [REG_ADDR_W-1:0]        addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (entries[idx].addr == addr) && (addr != '0)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging ALU and load results into one
// register-file write port, with operand bypass lookup.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [REG_ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic [REG_ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         stall,
    output logic                         wr,
    output logic [REG_ADDR_W-1:0]        addr_w,
    output logic [DATA_W-1:0]            data_w,
    input  logic [REG_ADDR_W-1:0]        fwd_addr_rs,
    input  logic [REG_ADDR_W-1:0]        fwd_addr_rt,
    output logic                         fwd_hit_rs,
    output logic [DATA_W-1:0]            fwd_data_rs,
    output logic                         fwd_hit_rt,
    output logic [DATA_W-1:0]            fwd_data_rt,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  alu_slot;
    logic           mem_acc;
    logic           alu_acc;
    logic           pop;

    // Keep two free slots so a dual request never has to be split.
    assign stall    = cnt > CW'(DEPTH - 2);
    assign mem_acc  = !stall && mem_valid && (mem_addr != '0);
    assign alu_acc  = !stall && alu_valid && (alu_addr != '0);
    assign alu_slot = mem_acc ? tail + PW'(1) : tail;
    assign pop      = cnt != '0;

    assign count  = cnt;
    assign wr     = pop;
    assign addr_w = pop ? entries[head].addr : '0;
    assign data_w = pop ? entries[head].data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            head <= head + PW'(pop);
            tail <= tail + PW'(mem_acc) + PW'(alu_acc);
            cnt  <= cnt + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
            if (pop)
                valid[head] <= 1'b0;
            if (mem_acc)
                valid[tail] <= 1'b1;
            if (alu_acc)
                valid[alu_slot] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_acc)
                entries[tail] <= '{addr: mem_addr, data: mem_data};
            if (alu_acc)
                entries[alu_slot] <= '{addr: alu_addr, data: alu_data};
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .addr    (fwd_addr_rs),
        .hit     (fwd_hit_rs),
        .data    (fwd_data_rs)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .addr    (fwd_addr_rt),
        .hit     (fwd_hit_rt),
        .data    (fwd_data_rt)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_stall;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_hrs;
        logic [31:0] e_drs;
        logic        e_hrt;
        logic [31:0] e_drt;
        int          e_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        stall;
    logic        wr;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [4:0]  fwd_addr_rs;
    logic [4:0]  fwd_addr_rt;
    logic        fwd_hit_rs;
    logic [31:0] fwd_data_rs;
    logic        fwd_hit_rt;
    logic [31:0] fwd_data_rt;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs [24];
    ent_t mq [$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .stall       (stall),
        .wr          (wr),
        .addr_w      (addr_w),
        .data_w      (data_w),
        .fwd_addr_rs (fwd_addr_rs),
        .fwd_addr_rt (fwd_addr_rt),
        .fwd_hit_rs  (fwd_hit_rs),
        .fwd_data_rs (fwd_data_rs),
        .fwd_hit_rt  (fwd_hit_rt),
        .fwd_data_rt (fwd_data_rt),
        .count       (count)
    );

    task automatic chk(input string name, input int step,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
        end
    endtask

    function automatic vec_t v(input logic rst,
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic es, input logic ew, input logic [4:0] ea,
        input logic [31:0] ed, input logic hrs, input logic [31:0] drs,
        input logic hrt, input logic [31:0] drt, input int ec);
        vec_t r;
        r.rst = rst; r.av = av; r.aa = aa; r.ad = ad;
        r.mv = mv; r.ma = ma; r.md = md; r.rs = rs; r.rt = rt;
        r.e_stall = es; r.e_wr = ew; r.e_addr = ea; r.e_data = ed;
        r.e_hrs = hrs; r.e_drs = drs; r.e_hrt = hrt; r.e_drt = drt;
        r.e_cnt = ec;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                         input logic [31:0] md, input logic [4:0] rs, input logic [4:0] rt);
        reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        fwd_addr_rs = rs; fwd_addr_rt = rt;
    endtask

    function automatic ent_t lookup(input logic [4:0] a);
        ent_t r;
        r.addr = 5'd0;
        r.data = 32'd0;
        if (a != 5'd0)
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].addr == a) begin
                    r.addr = 5'd1;
                    r.data = mq[i].data;
                    break;
                end
        return r;
    endfunction

    initial begin
        ent_t fr;
        ent_t ft;
        ent_t e;
        logic m_stall;

        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // rst av aa ad mv ma md rs rt | stall wr addr data hrs drs hrt drt cnt
        vecs[0]  = v(1, 0,0,0,              0,0,0,              0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[1]  = v(0, 1,5,32'h1234,       0,0,0,              5,0,  0,0,0,0,             0,0,0,0,0);
        vecs[2]  = v(0, 0,0,0,              0,0,0,              5,5,  0,1,5,32'h1234,      1,32'h1234,1,32'h1234,1);
        vecs[3]  = v(0, 0,0,0,              0,0,0,              5,0,  0,0,0,0,             0,0,0,0,0);
        vecs[4]  = v(0, 1,3,32'hBBBB,       1,3,32'hAAAA,       3,0,  0,0,0,0,             0,0,0,0,0);
        vecs[5]  = v(0, 0,0,0,              0,0,0,              3,3,  0,1,3,32'hAAAA,      1,32'hBBBB,1,32'hBBBB,2);
        vecs[6]  = v(0, 0,0,0,              0,0,0,              3,0,  0,1,3,32'hBBBB,      1,32'hBBBB,0,0,1);
        vecs[7]  = v(0, 0,0,0,              0,0,0,              3,0,  0,0,0,0,             0,0,0,0,0);
        vecs[8]  = v(0, 1,0,32'hFFFF,       0,0,0,              0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[9]  = v(0, 0,0,0,              0,0,0,              0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[10] = v(0, 1,2,32'h22,         1,1,32'h11,         0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[11] = v(0, 1,5,32'h55,         1,4,32'h44,         2,1,  0,1,1,32'h11,        1,32'h22,1,32'h11,2);
        vecs[12] = v(0, 1,7,32'h77,         1,6,32'h66,         6,5,  1,1,2,32'h22,        0,0,1,32'h55,3);
        vecs[13] = v(0, 0,0,0,              0,0,0,              7,4,  0,1,4,32'h44,        0,0,1,32'h44,2);
        vecs[14] = v(0, 0,0,0,              0,0,0,              5,0,  0,1,5,32'h55,        1,32'h55,0,0,1);
        vecs[15] = v(0, 0,0,0,              0,0,0,              0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[16] = v(0, 1,9,32'h99,         1,8,32'h88,         0,0,  0,0,0,0,             0,0,0,0,0);
        vecs[17] = v(0, 1,11,32'hB0,        1,10,32'hA0,        8,9,  0,1,8,32'h88,        1,32'h88,1,32'h99,2);
        vecs[18] = v(1, 1,12,32'hC0,        0,0,0,              9,11, 1,1,9,32'h99,        1,32'h99,1,32'hB0,3);
        vecs[19] = v(0, 0,0,0,              0,0,0,              9,11, 0,0,0,0,             0,0,0,0,0);
        vecs[20] = v(0, 0,0,0,              0,0,0,              12,10,0,0,0,0,             0,0,0,0,0);
        vecs[21] = v(0, 1,13,32'hD0,        0,0,0,              13,0, 0,0,0,0,             0,0,0,0,0);
        vecs[22] = v(0, 0,0,0,              0,0,0,              13,0, 0,1,13,32'hD0,       1,32'hD0,0,0,1);
        vecs[23] = v(0, 0,0,0,              0,0,0,              13,0, 0,0,0,0,             0,0,0,0,0);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad,
                  vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].rs, vecs[i].rt);
            #1;
            chk("stall",   i, 32'(stall),       32'(vecs[i].e_stall));
            chk("wr",      i, 32'(wr),          32'(vecs[i].e_wr));
            chk("addr_w",  i, 32'(addr_w),      32'(vecs[i].e_addr));
            chk("data_w",  i, data_w,           vecs[i].e_data);
            chk("hit_rs",  i, 32'(fwd_hit_rs),  32'(vecs[i].e_hrs));
            chk("data_rs", i, fwd_data_rs,      vecs[i].e_drs);
            chk("hit_rt",  i, 32'(fwd_hit_rt),  32'(vecs[i].e_hrt));
            chk("data_rt", i, fwd_data_rt,      vecs[i].e_drt);
            chk("count",   i, 32'(count),       32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end

        // Random traffic; the model starts from the empty queue left above.
        mq.delete();
        for (int s = 0; s < 600; s++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            m_stall = (DEPTH - mq.size()) < 2;
            fr = lookup(fwd_addr_rs);
            ft = lookup(fwd_addr_rt);
            chk("r_stall",   s, 32'(stall),      32'(m_stall));
            chk("r_count",   s, 32'(count),      32'(mq.size()));
            chk("r_wr",      s, 32'(wr),         32'(mq.size() != 0));
            chk("r_addr_w",  s, 32'(addr_w),     mq.size() != 0 ? 32'(mq[0].addr) : 32'd0);
            chk("r_data_w",  s, data_w,          mq.size() != 0 ? mq[0].data : 32'd0);
            chk("r_hit_rs",  s, 32'(fwd_hit_rs), 32'(fr.addr));
            chk("r_data_rs", s, fwd_data_rs,     fr.data);
            chk("r_hit_rt",  s, 32'(fwd_hit_rt), 32'(ft.addr));
            chk("r_data_rt", s, fwd_data_rt,     ft.data);
            @(posedge clk);
            if (reset) begin
                mq.delete();
            end else begin
                if (mq.size() != 0)
                    void'(mq.pop_front());
                if (!m_stall && mem_valid && mem_addr != 5'd0) begin
                    e.addr = mem_addr; e.data = mem_data;
                    mq.push_back(e);
                end
                if (!m_stall && alu_valid && alu_addr != 5'd0) begin
                    e.addr = alu_addr; e.data = alu_data;
                    mq.push_back(e);
                end
            end
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
